// File: rtl/blob_binarize.sv
// Grayscale-to-foreground front end for the blob labeller: threshold, 3-tap
// horizontal majority denoise, border suppression and frame handshake.
module blob_binarize #(
  parameter int IMG_COL = 800,
  parameter int IMG_ROW = 600,
  parameter int PIX_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [PIX_W-1:0] i_thresh,
  input  logic             i_invert,
  output logic             o_seq,
  output logic             o_seq_valid,
  output logic             o_frame_active,
  output logic             o_frame_done,
  output logic [19:0]      o_ones_count
);

  localparam int COL_W = $clog2(IMG_COL);
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [PIX_W-1:0]   thr_q;
  logic               inv_q;
  logic               tap_prev_q, tap_cur_q;

  logic               b_new;
  logic               maj;
  logic               last_pix;
  logic               start_frame;
  logic               accept;
  logic               emit_v;
  logic               emit_b;
  logic               done_d;

  assign b_new    = (i_pix > thr_q) ^ inv_q;
  assign maj      = (tap_prev_q & tap_cur_q) | (tap_prev_q & b_new) | (tap_cur_q & b_new);
  assign last_pix = (col_q == COL_W'(IMG_COL - 1)) && (row_q == ROW_W'(IMG_ROW - 1));

  assign o_frame_active = (state_q != S_IDLE);

  // Each accepted pixel emits the filtered result for the previous column;
  // column 0 of a later row emits the previous row's right border instead.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    accept      = 1'b0;
    emit_v      = 1'b0;
    emit_b      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_STREAM;
          start_frame = 1'b1;
        end
      end
      S_STREAM: begin
        if (!i_start) begin
          state_d = S_IDLE;
        end else if (i_pix_valid) begin
          accept = 1'b1;
          if (col_q == '0) begin
            emit_v = (row_q != '0);
          end else begin
            emit_v = 1'b1;
            emit_b = (col_q == COL_W'(1)) ? 1'b0 : maj;
          end
          if (last_pix) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!i_start) begin
          state_d = S_IDLE;
        end else begin
          emit_v  = 1'b1;
          done_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!i_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      thr_q        <= '0;
      inv_q        <= 1'b0;
      tap_prev_q   <= 1'b0;
      tap_cur_q    <= 1'b0;
      o_seq        <= 1'b0;
      o_seq_valid  <= 1'b0;
      o_frame_done <= 1'b0;
      o_ones_count <= '0;
    end else begin
      state_q      <= state_d;
      o_seq_valid  <= emit_v;
      o_seq        <= emit_v & emit_b;
      o_frame_done <= done_d;
      if (start_frame) begin
        thr_q        <= i_thresh;
        inv_q        <= i_invert;
        col_q        <= '0;
        row_q        <= '0;
        tap_prev_q   <= 1'b0;
        tap_cur_q    <= 1'b0;
        o_ones_count <= '0;
      end
      if (accept) begin
        tap_prev_q <= tap_cur_q;
        tap_cur_q  <= b_new;
        if (col_q == COL_W'(IMG_COL - 1)) begin
          col_q <= '0;
          row_q <= (row_q == ROW_W'(IMG_ROW - 1)) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
      if (emit_v && emit_b) o_ones_count <= o_ones_count + 20'd1;
    end
  end

endmodule

// File: tb/tb_blob_binarize.sv
// Self-checking bench for blob_binarize on a small 8x2 frame: directed table,
// randomized frames against a behavioural model, reset and abort sequences.
module tb_blob_binarize;

  localparam int COL  = 8;
  localparam int ROW  = 2;
  localparam int NPIX = COL * ROW;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_pix_valid = 1'b0;
  logic [7:0]  i_pix = '0;
  logic [7:0]  i_thresh = '0;
  logic        i_invert = 1'b0;
  logic        o_seq;
  logic        o_seq_valid;
  logic        o_frame_active;
  logic        o_frame_done;
  logic [19:0] o_ones_count;

  blob_binarize #(.IMG_COL(COL), .IMG_ROW(ROW), .PIX_W(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_start        (i_start),
    .i_pix_valid    (i_pix_valid),
    .i_pix          (i_pix),
    .i_thresh       (i_thresh),
    .i_invert       (i_invert),
    .o_seq          (o_seq),
    .o_seq_valid    (o_seq_valid),
    .o_frame_active (o_frame_active),
    .o_frame_done   (o_frame_done),
    .o_ones_count   (o_ones_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string      name;
    logic [7:0] pix [COL];
    logic [7:0] thr;
    logic       inv;
    int         gap_pct;
    logic       thr_change;
    logic [7:0] exp_row;
    int         exp_ones;
  } vec_t;

  vec_t       vec [7];
  logic [7:0] frame_pix [NPIX];
  bit         out_q [$];
  int         done_cnt;
  int         bad_idle;
  int         checks = 0;
  int         failures = 0;

  // Capture every emitted bit; o_seq must be low whenever o_seq_valid is low
  always @(negedge i_clk) begin
    if (o_seq_valid) out_q.push_back(o_seq);
    else if (o_seq !== 1'b0) bad_idle++;
    if (o_frame_done) done_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference: binarize, then majority of three neighbours inside a row,
  // borders forced to background. Bit index = row*COL + col.
  function automatic logic [NPIX-1:0] modelSeq(input logic [7:0] thr, input logic inv);
    logic [NPIX-1:0] s;
    int              b [NPIX];
    s = '0;
    for (int i = 0; i < NPIX; i++) b[i] = ((frame_pix[i] > thr) ? 1 : 0) ^ (inv ? 1 : 0);
    for (int r = 0; r < ROW; r++)
      for (int c = 1; c < COL - 1; c++)
        s[r*COL + c] = (b[r*COL+c-1] + b[r*COL+c] + b[r*COL+c+1]) >= 2;
    return s;
  endfunction

  function automatic int onesIn(input logic [NPIX-1:0] s, input int n);
    int k = 0;
    for (int i = 0; i < n; i++) k += s[i] ? 1 : 0;
    return k;
  endfunction

  // Drive one frame from frame_pix. abort_at >= 0 drops i_start after that
  // many accepted pixels.
  task automatic applyStimulus(input string name, input logic [7:0] thr, input logic inv,
                               input int gap_pct, input logic thr_change, input int abort_at,
                               input logic [NPIX-1:0] exp_seq);
    logic [NPIX-1:0] got;
    int              n_acc;
    @(negedge i_clk);
    out_q.delete();
    done_cnt = 0;
    bad_idle = 0;
    i_thresh = thr;
    i_invert = inv;
    i_start  = 1'b1;
    i_pix_valid = 1'b0;
    @(negedge i_clk);
    checkOutput({name, ".active_entry"}, 32'(o_frame_active), 32'd1);
    n_acc = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == abort_at) break;
      for (int g = 0; g < 20 && $urandom_range(99) < gap_pct; g++) begin
        i_pix_valid = 1'b0;
        i_pix = 8'($urandom);
        @(negedge i_clk);
      end
      i_pix_valid = 1'b1;
      i_pix = frame_pix[i];
      if (thr_change && i == 3) i_thresh = ~thr;
      @(negedge i_clk);
      n_acc++;
    end
    i_pix_valid = 1'b0;
    if (abort_at >= 0) begin
      i_start = 1'b0;
      @(negedge i_clk);
      checkOutput({name, ".abort_active"}, 32'(o_frame_active), 32'd0);
      repeat (4) @(negedge i_clk);
      checkOutput({name, ".abort_outputs"}, 32'(out_q.size()), 32'(n_acc - 1));
      checkOutput({name, ".abort_done"}, 32'(done_cnt), 32'd0);
      checkOutput({name, ".abort_count"}, 32'(o_ones_count), 32'(onesIn(exp_seq, n_acc - 1)));
      return;
    end
    repeat (4) @(negedge i_clk);
    got = '0;
    for (int i = 0; i < NPIX && i < out_q.size(); i++) got[i] = out_q[i];
    checkOutput({name, ".n_outputs"}, 32'(out_q.size()), 32'(NPIX));
    checkOutput({name, ".seq"}, 32'(got), 32'(exp_seq));
    checkOutput({name, ".ones_count"}, 32'(o_ones_count), 32'(onesIn(exp_seq, NPIX)));
    checkOutput({name, ".done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({name, ".seq_when_idle"}, 32'(bad_idle), 32'd0);
    checkOutput({name, ".active_hold"}, 32'(o_frame_active), 32'd1);
    i_start = 1'b0;
    @(negedge i_clk);
    checkOutput({name, ".active_drop"}, 32'(o_frame_active), 32'd0);
    checkOutput({name, ".count_kept"}, 32'(o_ones_count), 32'(onesIn(exp_seq, NPIX)));
  endtask

  initial begin
    vec[0] = '{name: "uniform",  pix: '{200,200,200,200,200,200,200,200}, thr: 8'd100, inv: 1'b0,
               gap_pct: 0,  thr_change: 1'b0, exp_row: 8'b0111_1110, exp_ones: 12};
    vec[1] = '{name: "isolated", pix: '{0,0,200,0,0,0,0,0},               thr: 8'd100, inv: 1'b0,
               gap_pct: 0,  thr_change: 1'b0, exp_row: 8'b0000_0000, exp_ones: 0};
    vec[2] = '{name: "pair",     pix: '{0,200,200,0,0,0,0,0},             thr: 8'd100, inv: 1'b0,
               gap_pct: 0,  thr_change: 1'b0, exp_row: 8'b0000_0110, exp_ones: 4};
    vec[3] = '{name: "equal",    pix: '{100,100,100,100,100,100,100,100}, thr: 8'd100, inv: 1'b0,
               gap_pct: 0,  thr_change: 1'b0, exp_row: 8'b0000_0000, exp_ones: 0};
    vec[4] = '{name: "invert",   pix: '{100,100,100,100,100,100,100,100}, thr: 8'd100, inv: 1'b1,
               gap_pct: 0,  thr_change: 1'b0, exp_row: 8'b0111_1110, exp_ones: 12};
    vec[5] = '{name: "thr_mid",  pix: '{150,150,150,150,150,150,150,150}, thr: 8'd100, inv: 1'b0,
               gap_pct: 0,  thr_change: 1'b1, exp_row: 8'b0111_1110, exp_ones: 12};
    vec[6] = '{name: "gapped",   pix: '{200,200,200,200,200,200,200,200}, thr: 8'd100, inv: 1'b0,
               gap_pct: 50, thr_change: 1'b0, exp_row: 8'b0111_1110, exp_ones: 12};

    repeat (2) @(negedge i_clk);
    checkOutput("reset.valid",  32'(o_seq_valid),    32'd0);
    checkOutput("reset.active", 32'(o_frame_active), 32'd0);
    checkOutput("reset.count",  32'(o_ones_count),   32'd0);
    i_rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NPIX; i++) frame_pix[i] = vec[v].pix[i % COL];
      checkOutput({vec[v].name, ".table_ones"}, 32'(onesIn({vec[v].exp_row, vec[v].exp_row}, NPIX)),
                  32'(vec[v].exp_ones));
      applyStimulus(vec[v].name, vec[v].thr, vec[v].inv, vec[v].gap_pct, vec[v].thr_change, -1,
                    {vec[v].exp_row, vec[v].exp_row});
    end

    for (int f = 0; f < 8; f++) begin
      logic [7:0] thr;
      logic       inv;
      thr = 8'($urandom_range(40, 215));
      inv = 1'($urandom_range(1));
      for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'($urandom);
      applyStimulus($sformatf("rand%0d", f), thr, inv, (f % 3) * 25, 1'b0, -1, modelSeq(thr, inv));
    end

    // Abort partway through row 0
    for (int i = 0; i < NPIX; i++) frame_pix[i] = 8'd200;
    applyStimulus("abort", 8'd100, 1'b0, 0, 1'b0, 6, modelSeq(8'd100, 1'b0));

    // Asynchronous reset in the middle of a frame
    @(negedge i_clk);
    out_q.delete();
    i_thresh = 8'd100;
    i_invert = 1'b0;
    i_start  = 1'b1;
    @(negedge i_clk);
    for (int i = 0; i < 5; i++) begin
      i_pix_valid = 1'b1;
      i_pix = 8'd200;
      @(negedge i_clk);
    end
    checkOutput("pre_reset.count", 32'(o_ones_count), 32'd3);
    #2 i_rst = 1'b1;
    #1;
    checkOutput("midreset.valid",  32'(o_seq_valid),    32'd0);
    checkOutput("midreset.seq",    32'(o_seq),          32'd0);
    checkOutput("midreset.active", 32'(o_frame_active), 32'd0);
    checkOutput("midreset.done",   32'(o_frame_done),   32'd0);
    checkOutput("midreset.count",  32'(o_ones_count),   32'd0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    out_q.delete();
    repeat (6) @(negedge i_clk);
    checkOutput("post_reset.outputs", 32'(out_q.size()), 32'd0);
    checkOutput("post_reset.active",  32'(o_frame_active), 32'd0);
    i_pix_valid = 1'b0;

    for (int i = 0; i < NPIX; i++) frame_pix[i] = vec[2].pix[i % COL];
    applyStimulus("after_reset", 8'd100, 1'b0, 0, 1'b0, -1, modelSeq(8'd100, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
